// File: rtl/rs_bank.sv
// ---------------------------------------------------------------------------
// rs_bank -- one reservation-station bank.
//
// Holds RS_SZ scheduler entries. Each cycle up to DISP_W new entries are
// allocated into the lowest free slots. CDB broadcasts wake up waiting
// sources. Issue-clear lanes free slots, and a mispredict flushes the bank.
//
// Entry layout (ENTRY_W bits, MSB first):
//   {valid, src1_ready, src1_tag[TAG_W], src2_ready, src2_tag[TAG_W],
//    payload[PAY_W]}
//
// Ports
//   clock, reset     rising-edge clock, synchronous active-high reset
//   mispredict       drop every valid entry at the next edge
//   disp_valid       per-lane dispatch request            [DISP_W]
//   disp_entries     entries to insert, lane 0 in the LSBs [DISP_W*ENTRY_W]
//                    (the valid field is ignored)
//   cdb_valid        per-lane tag broadcast               [CDB_W]
//   cdb_tags         completing physical tags             [CDB_W*TAG_W]
//   clear_valid      per-lane issue clear                 [CLR_W]
//   clear_idxs       slot indices to free                 [CLR_W*IDX_W]
//   entries          registered bank contents             [RS_SZ*ENTRY_W]
//   free_count       RS_SZ minus the number of registered valid slots
//   disp_accepted    per-lane acceptance, combinational   [DISP_W]
// ---------------------------------------------------------------------------

`ifndef RS_ALU_SZ
`define RS_ALU_SZ 8
`endif
`ifndef NUM_FU_ALU
`define NUM_FU_ALU 2
`endif

// ---------------------------------------------------------------------------
// rs_bank_slot -- storage and wakeup for a single bank entry.
//
//   flush_i     mispredict: drop valid
//   wr_en_i     allocate this slot with wr_entry_i (slot is known free)
//   clr_i       issue clear of this slot
//   cdb_*       broadcast tags used for wakeup and dispatch bypass
//   entry_o     registered entry
// ---------------------------------------------------------------------------
module rs_bank_slot #(
    parameter int TAG_W = 6,
    parameter int PAY_W = 16,
    parameter int CDB_W = 2,
    localparam int ENTRY_W = 2*TAG_W + PAY_W + 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   wr_en_i,
    input  logic [ENTRY_W-1:0]     wr_entry_i,
    input  logic                   clr_i,
    input  logic [CDB_W-1:0]       cdb_valid_i,
    input  logic [CDB_W*TAG_W-1:0] cdb_tags_i,
    output logic [ENTRY_W-1:0]     entry_o
);
    localparam int S2T = PAY_W;
    localparam int S2R = PAY_W + TAG_W;
    localparam int S1T = PAY_W + TAG_W + 1;
    localparam int S1R = PAY_W + 2*TAG_W + 1;
    localparam int VLD = ENTRY_W - 1;

    logic [ENTRY_W-1:0] entry_q, entry_d;

    function automatic logic cdb_hit(input logic [CDB_W-1:0]       vld,
                                     input logic [CDB_W*TAG_W-1:0] tags,
                                     input logic [TAG_W-1:0]       tag);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < CDB_W; c++) begin
            if (vld[c] && (tags[c*TAG_W +: TAG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Priority: flush > allocate > clear > wakeup. Allocation only ever
    // targets an invalid slot, so a same-cycle clear of it is a no-op and
    // losing to the write is correct.
    always_comb begin
        entry_d = entry_q;
        if (flush_i) begin
            entry_d[VLD] = 1'b0;
        end else if (wr_en_i) begin
            entry_d      = wr_entry_i;
            entry_d[VLD] = 1'b1;
            // bypass: a tag completing this very cycle is stored ready
            entry_d[S1R] = wr_entry_i[S1R] |
                           cdb_hit(cdb_valid_i, cdb_tags_i, wr_entry_i[S1T +: TAG_W]);
            entry_d[S2R] = wr_entry_i[S2R] |
                           cdb_hit(cdb_valid_i, cdb_tags_i, wr_entry_i[S2T +: TAG_W]);
        end else if (clr_i) begin
            entry_d[VLD] = 1'b0;
        end else if (entry_q[VLD]) begin
            // ready bits only ever set while the entry lives
            if (cdb_hit(cdb_valid_i, cdb_tags_i, entry_q[S1T +: TAG_W])) entry_d[S1R] = 1'b1;
            if (cdb_hit(cdb_valid_i, cdb_tags_i, entry_q[S2T +: TAG_W])) entry_d[S2R] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) entry_q <= '0;
        else       entry_q <= entry_d;
    end

    assign entry_o = entry_q;
endmodule

// ---------------------------------------------------------------------------
// rs_bank -- top
// ---------------------------------------------------------------------------
module rs_bank #(
    parameter int RS_SZ  = `RS_ALU_SZ,
    parameter int DISP_W = 2,
    parameter int CDB_W  = `NUM_FU_ALU,
    parameter int CLR_W  = `NUM_FU_ALU,
    parameter int TAG_W  = 6,
    parameter int PAY_W  = 16,
    localparam int ENTRY_W = 2*TAG_W + PAY_W + 3,
    localparam int IDX_W   = (RS_SZ > 1) ? $clog2(RS_SZ) : 1,
    localparam int CNT_W   = $clog2(RS_SZ + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mispredict,
    input  logic [DISP_W-1:0]         disp_valid,
    input  logic [DISP_W*ENTRY_W-1:0] disp_entries,
    input  logic [CDB_W-1:0]          cdb_valid,
    input  logic [CDB_W*TAG_W-1:0]    cdb_tags,
    input  logic [CLR_W-1:0]          clear_valid,
    input  logic [CLR_W*IDX_W-1:0]    clear_idxs,
    output logic [RS_SZ*ENTRY_W-1:0]  entries,
    output logic [CNT_W-1:0]          free_count,
    output logic [DISP_W-1:0]         disp_accepted
);
    logic [RS_SZ-1:0]              valid_q;
    logic [RS_SZ-1:0]              slot_wr;
    logic [RS_SZ-1:0]              slot_clr;
    logic [RS_SZ-1:0][ENTRY_W-1:0] slot_wdata;
    logic [DISP_W-1:0]             acc;

    // Allocation: lanes in ascending order each grab the lowest slot that
    // is invalid in the registered state and not already claimed by an
    // earlier lane. Same-cycle clears are deliberately not visible here.
    always_comb begin
        slot_wr    = '0;
        slot_wdata = '0;
        acc        = '0;
        for (int l = 0; l < DISP_W; l++) begin
            for (int i = 0; i < RS_SZ; i++) begin
                if (disp_valid[l] && !acc[l] && !valid_q[i] && !slot_wr[i]) begin
                    acc[l]        = 1'b1;
                    slot_wr[i]    = 1'b1;
                    slot_wdata[i] = disp_entries[l*ENTRY_W +: ENTRY_W];
                end
            end
        end
    end

    assign disp_accepted = acc;

    // Clear decode: OR across lanes, so duplicate indices collapse.
    always_comb begin
        slot_clr = '0;
        for (int c = 0; c < CLR_W; c++) begin
            for (int i = 0; i < RS_SZ; i++) begin
                if (clear_valid[c] && (clear_idxs[c*IDX_W +: IDX_W] == IDX_W'(i)))
                    slot_clr[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < RS_SZ; g++) begin : g_slot
        rs_bank_slot #(
            .TAG_W (TAG_W),
            .PAY_W (PAY_W),
            .CDB_W (CDB_W)
        ) u_slot (
            .clock       (clock),
            .reset       (reset),
            .flush_i     (mispredict),
            .wr_en_i     (slot_wr[g]),
            .wr_entry_i  (slot_wdata[g]),
            .clr_i       (slot_clr[g]),
            .cdb_valid_i (cdb_valid),
            .cdb_tags_i  (cdb_tags),
            .entry_o     (entries[g*ENTRY_W +: ENTRY_W])
        );
        assign valid_q[g] = entries[g*ENTRY_W + ENTRY_W - 1];
    end

    always_comb begin
        free_count = CNT_W'(RS_SZ);
        for (int i = 0; i < RS_SZ; i++) begin
            free_count = free_count - CNT_W'(valid_q[i]);
        end
    end
endmodule

// File: tb/tb_rs_bank.sv
`timescale 1ns/1ps
module tb_rs_bank;
    localparam int RS_SZ   = 8;
    localparam int TAG_W   = 6;
    localparam int PAY_W   = 16;
    localparam int ENTRY_W = 2*TAG_W + PAY_W + 3;
    localparam int IDX_W   = 3;
    localparam int CNT_W   = 4;

    logic                     clock = 1'b0;
    logic                     reset, mispredict;
    logic [1:0]               disp_valid;
    logic [2*ENTRY_W-1:0]     disp_entries;
    logic [1:0]               cdb_valid;
    logic [2*TAG_W-1:0]       cdb_tags;
    logic [1:0]               clear_valid;
    logic [2*IDX_W-1:0]       clear_idxs;
    logic [RS_SZ*ENTRY_W-1:0] entries;
    logic [CNT_W-1:0]         free_count;
    logic [1:0]               disp_accepted;

    rs_bank #(.RS_SZ(RS_SZ), .DISP_W(2), .CDB_W(2), .CLR_W(2),
              .TAG_W(TAG_W), .PAY_W(PAY_W)) dut (
        .clock(clock), .reset(reset), .mispredict(mispredict),
        .disp_valid(disp_valid), .disp_entries(disp_entries),
        .cdb_valid(cdb_valid), .cdb_tags(cdb_tags),
        .clear_valid(clear_valid), .clear_idxs(clear_idxs),
        .entries(entries), .free_count(free_count),
        .disp_accepted(disp_accepted));

    always #5 clock = ~clock;

    typedef struct {
        logic             v;
        logic             r1;
        logic [TAG_W-1:0] t1;
        logic             r2;
        logic [TAG_W-1:0] t2;
        logic [PAY_W-1:0] pay;
    } ment_t;

    typedef struct {
        logic [1:0]  dv;
        logic [15:0] p0;
        logic [15:0] p1;
        logic [1:0]  exp_acc;
        int          exp_free;
    } vec_t;

    ment_t      m [RS_SZ];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] last_acc;

    function automatic logic [ENTRY_W-1:0] pack(input ment_t e);
        return {e.v, e.r1, e.t1, e.r2, e.t2, e.pay};
    endfunction

    function automatic ment_t unpack(input logic [ENTRY_W-1:0] b);
        ment_t e;
        {e.v, e.r1, e.t1, e.r2, e.t2, e.pay} = b;
        return e;
    endfunction

    function automatic ment_t ent(input int i);
        return unpack(entries[i*ENTRY_W +: ENTRY_W]);
    endfunction

    function automatic int model_free();
        int n = 0;
        for (int i = 0; i < RS_SZ; i++) if (!m[i].v) n++;
        return n;
    endfunction

    function automatic logic hit(input logic [TAG_W-1:0] t);
        return (cdb_valid[0] && cdb_tags[0 +: TAG_W] == t) ||
               (cdb_valid[1] && cdb_tags[TAG_W +: TAG_W] == t);
    endfunction

    function automatic logic cleared(input int i);
        return (clear_valid[0] && int'(clear_idxs[0 +: IDX_W]) == i) ||
               (clear_valid[1] && int'(clear_idxs[IDX_W +: IDX_W]) == i);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; mispredict = 1'b0;
        disp_valid = '0; disp_entries = '0;
        cdb_valid = '0; cdb_tags = '0;
        clear_valid = '0; clear_idxs = '0;
    endtask

    task automatic set_disp(input int l, input int r1, input int t1,
                            input int r2, input int t2, input int pay);
        disp_valid[l] = 1'b1;
        // valid field driven to 1 on purpose: the bank must ignore it
        disp_entries[l*ENTRY_W +: ENTRY_W] =
            {1'b1, 1'(r1), TAG_W'(t1), 1'(r2), TAG_W'(t2), PAY_W'(pay)};
    endtask

    task automatic set_cdb(input int l, input int tag);
        cdb_valid[l] = 1'b1;
        cdb_tags[l*TAG_W +: TAG_W] = TAG_W'(tag);
    endtask

    task automatic set_clr(input int l, input int idx);
        clear_valid[l] = 1'b1;
        clear_idxs[l*IDX_W +: IDX_W] = IDX_W'(idx);
    endtask

    // One clock: check acceptance against the model before the edge, advance
    // the model by the bank's rules, then check every registered output.
    task automatic step();
        int    fq[$];
        int    slot[2];
        logic [1:0] eacc;
        ment_t nm [RS_SZ];
        ment_t e;
        slot[0] = 0; slot[1] = 0;
        @(negedge clock);
        eacc = '0;
        for (int i = 0; i < RS_SZ; i++) if (!m[i].v) fq.push_back(i);
        for (int l = 0; l < 2; l++) begin
            if (disp_valid[l] && fq.size() > 0) begin
                eacc[l] = 1'b1;
                slot[l] = fq.pop_front();
            end
        end
        chk("disp_accepted", 64'(disp_accepted), 64'(eacc));
        last_acc = disp_accepted;
        nm = m;
        if (reset) begin
            for (int i = 0; i < RS_SZ; i++) nm[i] = '{default: 0};
        end else if (mispredict) begin
            for (int i = 0; i < RS_SZ; i++) nm[i].v = 1'b0;
        end else begin
            for (int i = 0; i < RS_SZ; i++) begin
                if (m[i].v) begin
                    if (cleared(i)) nm[i].v = 1'b0;
                    else begin
                        if (hit(m[i].t1)) nm[i].r1 = 1'b1;
                        if (hit(m[i].t2)) nm[i].r2 = 1'b1;
                    end
                end
            end
            for (int l = 0; l < 2; l++) begin
                if (eacc[l]) begin
                    e    = unpack(disp_entries[l*ENTRY_W +: ENTRY_W]);
                    e.v  = 1'b1;
                    e.r1 = e.r1 | hit(e.t1);
                    e.r2 = e.r2 | hit(e.t2);
                    nm[slot[l]] = e;
                end
            end
        end
        @(posedge clock);
        m = nm;
        #1;
        for (int i = 0; i < RS_SZ; i++)
            chk($sformatf("entry[%0d]", i), 64'(entries[i*ENTRY_W +: ENTRY_W]), 64'(pack(m[i])));
        chk("free_count", 64'(free_count), 64'(model_free()));
    endtask

    task automatic do_reset();
        idle(); reset = 1'b1;
        step();
        idle();
        chk("reset_free", 64'(free_count), 64'(RS_SZ));
    endtask

    vec_t tbl [5];

    initial begin
        for (int i = 0; i < RS_SZ; i++) m[i] = '{default: 0};
        idle();
        do_reset();

        // Fill the bank two lanes per cycle, then one more cycle on a full bank
        tbl[0] = '{2'b11, 16'hA000, 16'hA001, 2'b11, 6};
        tbl[1] = '{2'b11, 16'hA002, 16'hA003, 2'b11, 4};
        tbl[2] = '{2'b11, 16'hA004, 16'hA005, 2'b11, 2};
        tbl[3] = '{2'b11, 16'hA006, 16'hA007, 2'b11, 0};
        tbl[4] = '{2'b11, 16'hA008, 16'hA009, 2'b00, 0};
        for (int k = 0; k < 5; k++) begin
            idle();
            if (tbl[k].dv[0]) set_disp(0, 0, 1, 0, 2, int'(tbl[k].p0));
            if (tbl[k].dv[1]) set_disp(1, 0, 3, 0, 4, int'(tbl[k].p1));
            step();
            chk($sformatf("fill_acc[%0d]", k), 64'(last_acc), 64'(tbl[k].exp_acc));
            chk($sformatf("fill_free[%0d]", k), 64'(free_count), 64'(tbl[k].exp_free));
        end
        for (int i = 0; i < RS_SZ; i++) begin
            chk($sformatf("fill_order[%0d]", i), 64'(ent(i).pay), 64'(16'hA000 + i));
            chk($sformatf("fill_valid[%0d]", i), 64'(ent(i).v), 64'd1);
        end

        // Single hole at idx 5, both lanes request
        idle(); set_clr(0, 5); step();
        chk("hole_free", 64'(free_count), 64'd1);
        idle(); set_disp(0, 0, 1, 0, 2, 'hB000); set_disp(1, 0, 3, 0, 4, 'hB001); step();
        chk("hole_acc", 64'(last_acc), 64'b01);
        chk("hole_pay", 64'(ent(5).pay), 64'hB000);
        chk("hole_free_after", 64'(free_count), 64'd0);

        // Clear vs allocate on a full bank
        idle(); set_clr(0, 0); set_disp(0, 0, 1, 0, 2, 'hC000); step();
        chk("clr_alloc_acc", 64'(last_acc), 64'b00);
        chk("clr_alloc_v0", 64'(ent(0).v), 64'd0);
        idle(); set_disp(0, 0, 1, 0, 2, 'hC001); step();
        chk("clr_alloc_next_acc", 64'(last_acc), 64'b01);
        chk("clr_alloc_next_pay", 64'(ent(0).pay), 64'hC001);

        // Wakeup plus dispatch bypass on tag 17
        do_reset();
        idle(); set_disp(0, 0, 1, 0, 2, 'hD000); set_disp(1, 0, 3, 0, 4, 'hD001); step();
        idle(); set_disp(0, 0, 17, 0, 20, 'hD002); step();
        chk("wake_pre_r1", 64'(ent(2).r1), 64'd0);
        idle(); set_cdb(0, 17); set_disp(0, 0, 21, 0, 17, 'hD003); step();
        chk("wake_r1", 64'(ent(2).r1), 64'd1);
        chk("wake_r2_stays", 64'(ent(2).r2), 64'd0);
        chk("bypass_r2", 64'(ent(3).r2), 64'd1);
        chk("bypass_r1", 64'(ent(3).r1), 64'd0);

        // Clear + wakeup + duplicate clear on idx 3
        chk("dup_free_before", 64'(free_count), 64'd4);
        idle(); set_clr(0, 3); set_clr(1, 3); set_cdb(0, 21); step();
        chk("dup_v3", 64'(ent(3).v), 64'd0);
        chk("dup_free_after", 64'(free_count), 64'd5);
        chk("dup_v2_kept", 64'(ent(2).v), 64'd1);

        // Mispredict with six valid entries and a concurrent dispatch
        do_reset();
        for (int k = 0; k < 3; k++) begin
            idle(); set_disp(0, 0, 5, 0, 6, 'hE000 + 2*k); set_disp(1, 0, 7, 0, 8, 'hE001 + 2*k); step();
        end
        chk("misp_free_before", 64'(free_count), 64'd2);
        idle(); mispredict = 1'b1; set_disp(0, 0, 1, 0, 2, 'hE100); set_disp(1, 0, 1, 0, 2, 'hE101);
        set_cdb(0, 5); set_clr(0, 1); step();
        chk("misp_acc", 64'(last_acc), 64'b11);
        chk("misp_free", 64'(free_count), 64'd8);
        for (int i = 0; i < RS_SZ; i++) chk($sformatf("misp_v[%0d]", i), 64'(ent(i).v), 64'd0);

        // Reset mid-fill with activity on every input
        idle(); set_disp(0, 0, 1, 0, 2, 'hF000); set_disp(1, 0, 3, 0, 4, 'hF001); step();
        idle(); reset = 1'b1; mispredict = 1'b1; set_disp(0, 0, 1, 0, 2, 'hF002);
        set_cdb(0, 1); set_clr(0, 0); step();
        for (int i = 0; i < RS_SZ; i++)
            chk($sformatf("rst_zero[%0d]", i), 64'(entries[i*ENTRY_W +: ENTRY_W]), 64'd0);
        chk("rst_free", 64'(free_count), 64'd8);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            int r;
            idle();
            r = $urandom_range(0, 99);
            reset      = (r < 2);
            mispredict = (r >= 2 && r < 6);
            for (int l = 0; l < 2; l++) begin
                if ($urandom_range(0, 2) != 0)
                    set_disp(l, $urandom_range(0, 1), $urandom_range(0, 7),
                             $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 65535));
                if ($urandom_range(0, 1) != 0) set_cdb(l, $urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0) set_clr(l, $urandom_range(0, 7));
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rs_bank.md
RS_BANK -- requirements
Module: rs_bank

Interface
REQ-001 Parameter RS_SZ, default `RS_ALU_SZ: number of entries in this bank.
REQ-002 Parameter DISP_W, default 2: dispatch lanes per cycle.
REQ-003 Parameter CDB_W, default `NUM_FU_ALU: CDB broadcast lanes per cycle.
REQ-004 Parameter CLR_W, default `NUM_FU_ALU: issue-clear lanes per cycle.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 Port clock  in  1  rising-edge clock.
REQ-007 Port reset  in  1  synchronous active-high reset.
REQ-008 Port mispredict  in  1  flush all entries at next edge.
REQ-009 Port disp_valid  in  DISP_W  per-lane dispatch request.
REQ-010 Port disp_entries  in  DISP_W x RS_ENTRY  entries to insert (valid field ignored).
REQ-011 Port cdb_valid  in  CDB_W  per-lane tag broadcast.
REQ-012 Port cdb_tags  in  CDB_W x PHYS_TAG  completing physical tags.
REQ-013 Port clear_valid  in  CLR_W  per-lane issue clear.
REQ-014 Port clear_idxs  in  CLR_W x RS_IDX  local indices to free.
REQ-015 Port entries  out  RS_SZ x RS_ENTRY  registered bank contents, fed to the issue stage.
REQ-016 Port free_count  out  clog2(RS_SZ+1)  free entries this cycle, from registered valid bits only.
REQ-017 Port disp_accepted  out  DISP_W  per-lane acceptance, combinational.

Function
REQ-018 Allocation: lanes in ascending order take the lowest-index entries whose registered valid is 0; each free entry is used at most once per cycle.
REQ-019 A lane with disp_valid=1 and no remaining free entry SHALL have disp_accepted=0 and SHALL NOT be written; disp_accepted=0 for any lane with disp_valid=0.
REQ-020 Accepted entry is written at the next edge with valid=1 and with payload and tags from disp_entries.
REQ-021 Dispatch bypass: an accepted source whose tag matches any valid CDB lane in the same cycle SHALL be stored with ready=1.
REQ-022 Wakeup: for every valid entry, src1_ready/src2_ready SHALL be set at the next edge when the source tag matches any valid CDB lane; a ready bit is never cleared while the entry is valid.
REQ-023 Clear: each clear lane with clear_valid=1 SHALL set entries[clear_idxs].valid=0 at the next edge; a clear of an already-invalid entry is a no-op.
REQ-024 Clear and wakeup on the same entry in one cycle: the clear wins (valid=0).
REQ-025 A slot cleared in cycle N is not allocatable until cycle N+1; free_count ignores same-cycle clears.
REQ-026 Duplicate clear indices across lanes SHALL behave as a single clear.
REQ-027 Latency: dispatch-to-visible on entries is 1 cycle; CDB-to-ready is 1 cycle; clear-to-invalid is 1 cycle.
REQ-028 mispredict=1 SHALL clear all valid bits at the next edge, and dispatch, wakeup and clear in that cycle are discarded; disp_accepted is still computed.
REQ-029 free_count SHALL equal RS_SZ minus the popcount of the registered valid bits.

Reset
REQ-030 On reset, every entries[i] SHALL be zero (valid=0); free_count=RS_SZ one cycle after reset is sampled.
REQ-031 Reset takes priority over mispredict, dispatch, CDB and clear.
REQ-032 Reset asserted mid-operation discards all in-flight dispatch, wakeup and clear effects.

Verification
REQ-033 Fill the bank: RS_SZ=8 and DISP_W=2 with 2 lanes/cycle for 4 cycles -> entries 0..7 valid in order, free_count 8,6,4,2,0; a 5th cycle -> disp_accepted=00.
REQ-034 Partial space: 1 entry free at idx 5 and both lanes valid -> lane0 goes to idx5, accepted=01; lane1 is dropped.
REQ-035 Wakeup: entry 2 with src1_tag=17 and not ready, cdb tag 17 -> src1_ready=1 next cycle; a dispatch with src2_tag=17 in the same cycle is stored ready.
REQ-036 Clear versus allocate: clear idx 0 while the bank is full and dispatch is valid -> not accepted this cycle; the next cycle's dispatch lands in idx 0.
REQ-037 Simultaneous clear and wakeup on idx 3, plus duplicate clears of idx 3 -> idx3 valid=0, free_count +1.
REQ-038 Mispredict with 6 valid entries and a concurrent dispatch -> all invalid next cycle, free_count=8; reset mid-fill -> all zero.
